mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mips_defs.sv | 56 +++++
 rtl/load_align.sv | 29 ++
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: memory ALU op codes, MEM-stage FSM states
// and the lane/alignment helpers used when issuing data bus transactions.
package mips_defs;

  localparam logic [7:0] ALUOP_BUBBLE = 8'h11;
  localparam logic [7:0] ALUOP_LB     = 8'h90;
  localparam logic [7:0] ALUOP_LBU    = 8'h91;
  localparam logic [7:0] ALUOP_LH     = 8'h92;
  localparam logic [7:0] ALUOP_LHU    = 8'h93;
  localparam logic [7:0] ALUOP_LW     = 8'h94;
  localparam logic [7:0] ALUOP_SB     = 8'h98;
  localparam logic [7:0] ALUOP_SH     = 8'h99;
  localparam logic [7:0] ALUOP_SW     = 8'h9A;

  localparam int unsigned TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {ALUOP_SB, ALUOP_SH, ALUOP_SW};
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    case (op)
      ALUOP_LH, ALUOP_LHU, ALUOP_SH: return addr_lo[0];
      ALUOP_LW, ALUOP_SW:            return |addr_lo;
      default:                       return 1'b0;
    endcase
  endfunction

  // Little-endian lane enables: byte 0 lives in bits [7:0].
  function automatic logic [3:0] byte_enable(input logic [7:0] op, input logic [1:0] addr_lo);
    case (op)
      ALUOP_LB, ALUOP_LBU, ALUOP_SB: return 4'b0001 << addr_lo;
      ALUOP_LH, ALUOP_LHU, ALUOP_SH: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:                       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] din);
    case (op)
      ALUOP_SB: return {4{din[7:0]}};
      ALUOP_SH: return {2{din[15:0]}};
      default:  return din;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a bus read word and extends it
// to 32 bits according to the load op.
module load_align
  import mips_defs::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    w_byte = rdata[{addr, 3'b000} +: 8];
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      ALUOP_LB:  data = {{24{w_byte[7]}}, w_byte};
      ALUOP_LBU: data = {24'h0, w_byte};
      ALUOP_LH:  data = {{16{w_half[15]}}, w_half};
      ALUOP_LHU: data = {16'h0, w_half};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores on the data bus, stalls upstream while a
// transaction is outstanding, and registers the MEM/WB fields.
module mem_access_unit
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wa,
  input  logic        mem_wreg,
  input  logic        mem_mreg,
  input  logic        mem_whilo,
  input  logic [63:0] mem_hilo,
  input  logic [31:0] mem_wd,
  input  logic [31:0] mem_din,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  wb_wa,
  output logic        wb_wreg,
  output logic [31:0] wb_wd,
  output logic        wb_whilo,
  output logic [63:0] wb_hilo,
  output logic        stall_req,
  output logic        addr_err,
  output logic        bus_err
);

  mem_state_t  r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wd;
  logic [31:0] r_rdata;
  logic [4:0]  r_wa;
  logic        r_wreg;
  logic        r_whilo;
  logic [63:0] r_hilo;
  logic        r_timeout;

  logic        r_dbus_req;
  logic        r_dbus_we;
  logic [31:0] r_dbus_addr;
  logic [3:0]  r_dbus_be;
  logic [31:0] r_dbus_wdata;

  logic [4:0]  r_wb_wa;
  logic        r_wb_wreg;
  logic [31:0] r_wb_wd;
  logic        r_wb_whilo;
  logic [63:0] r_wb_hilo;
  logic        r_addr_err;
  logic        r_bus_err;

  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_issue;
  logic [31:0] w_load_data;
  logic        w_unused;

  // The load/store decision comes from the op code alone; mem_mreg is redundant here.
  assign w_unused     = mem_mreg;
  assign w_is_mem     = is_load(mem_aluop) | is_store(mem_aluop);
  assign w_misaligned = misaligned(mem_aluop, mem_wd[1:0]);
  assign w_issue      = (r_state == IDLE) & w_is_mem & ~w_misaligned;
  assign stall_req    = rst_n & (w_issue | (r_state == BUSY));

  load_align u_load_align (
    .op    (r_op),
    .addr  (r_addr_lo),
    .rdata (r_rdata),
    .data  (w_load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset is asynchronous and clears all state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_op         <= 8'd0;
      r_addr_lo    <= 2'd0;
      r_wd         <= 32'd0;
      r_rdata      <= 32'd0;
      r_wa         <= 5'd0;
      r_wreg       <= 1'b0;
      r_whilo      <= 1'b0;
      r_hilo       <= 64'd0;
      r_timeout    <= 1'b0;
      r_dbus_req   <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_dbus_addr  <= 32'd0;
      r_dbus_be    <= 4'd0;
      r_dbus_wdata <= 32'd0;
      r_wb_wa      <= 5'd0;
      r_wb_wreg    <= 1'b0;
      r_wb_wd      <= 32'd0;
      r_wb_whilo   <= 1'b0;
      r_wb_hilo    <= 64'd0;
      r_addr_err   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wb_wa   <= mem_wa;
          r_wb_wd   <= mem_wd;
          r_wb_hilo <= mem_hilo;
          if (w_is_mem) begin
            // Memory ops never write back on this edge: either they are
            // issued (result arrives after DONE) or they fault.
            r_wb_wreg  <= 1'b0;
            r_wb_whilo <= 1'b0;
            if (w_misaligned) begin
              r_addr_err <= 1'b1;
            end else begin
              r_state      <= BUSY;
              r_cnt        <= 8'd0;
              r_timeout    <= 1'b0;
              r_op         <= mem_aluop;
              r_addr_lo    <= mem_wd[1:0];
              r_wd         <= mem_wd;
              r_wa         <= mem_wa;
              r_wreg       <= mem_wreg;
              r_whilo      <= mem_whilo;
              r_hilo       <= mem_hilo;
              r_dbus_req   <= 1'b1;
              r_dbus_we    <= is_store(mem_aluop);
              r_dbus_addr  <= {mem_wd[31:2], 2'b00};
              r_dbus_be    <= byte_enable(mem_aluop, mem_wd[1:0]);
              r_dbus_wdata <= is_store(mem_aluop) ? store_data(mem_aluop, mem_din) : 32'd0;
            end
          end else begin
            r_wb_wreg  <= mem_wreg;
            r_wb_whilo <= mem_whilo;
          end
        end

        BUSY: begin
          if (dbus_ack || (r_cnt == 8'(TIMEOUT - 1))) begin
            r_state      <= DONE;
            r_dbus_req   <= 1'b0;
            r_dbus_we    <= 1'b0;
            r_dbus_addr  <= 32'd0;
            r_dbus_be    <= 4'd0;
            r_dbus_wdata <= 32'd0;
            if (dbus_ack) begin
              r_rdata <= dbus_rdata;
            end else begin
              r_timeout <= 1'b1;
              r_bus_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        DONE: begin
          r_wb_wa    <= r_wa;
          r_wb_wd    <= is_load(r_op) ? w_load_data : r_wd;
          r_wb_hilo  <= r_hilo;
          r_wb_wreg  <= r_wreg & ~r_timeout;
          r_wb_whilo <= r_whilo & ~r_timeout;
          r_cnt      <= 8'd0;
          r_state    <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign dbus_req   = r_dbus_req;
  assign dbus_we    = r_dbus_we;
  assign dbus_addr  = r_dbus_addr;
  assign dbus_be    = r_dbus_be;
  assign dbus_wdata = r_dbus_wdata;
  assign wb_wa      = r_wb_wa;
  assign wb_wreg    = r_wb_wreg;
  assign wb_wd      = r_wb_wd;
  assign wb_whilo   = r_wb_whilo;
  assign wb_hilo    = r_wb_hilo;
  assign addr_err   = r_addr_err;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus random
// loads/stores compared against an arithmetic model of the bus and lane rules.
module tb_mem_access_unit;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wa;
  logic        mem_wreg, mem_mreg, mem_whilo;
  logic [63:0] mem_hilo;
  logic [31:0] mem_wd, mem_din;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wa;
  logic        wb_wreg, wb_whilo;
  logic [31:0] wb_wd;
  logic [63:0] wb_hilo;
  logic        stall_req, addr_err, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_aluop(mem_aluop), .mem_wa(mem_wa), .mem_wreg(mem_wreg), .mem_mreg(mem_mreg),
    .mem_whilo(mem_whilo), .mem_hilo(mem_hilo), .mem_wd(mem_wd), .mem_din(mem_din),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_wa(wb_wa), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_whilo(wb_whilo), .wb_hilo(wb_hilo),
    .stall_req(stall_req), .addr_err(addr_err), .bus_err(bus_err)
  );

  typedef struct packed {
    int          stall_cycles;
    int          busy_cycles;
    logic        req_dropped;
    logic        unstable;
    logic        hung;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        done_req;
    logic        done_zero;
    logic        done_bus_err;
    logic        done_addr_err;
    logic        done_wreg;
    logic        done_whilo;
    logic        post_bus_err;
    logic        post_addr_err;
    logic        post_stall;
    logic [4:0]  sent_wa;
    logic [4:0]  wb_wa;
    logic        wb_wreg;
    logic [31:0] wb_wd;
  } obs_t;

  // Reference model: access size in bytes, derived from the op table.
  function automatic int op_size(input logic [7:0] op);
    case (op)
      8'h90, 8'h91, 8'h98: return 1;
      8'h92, 8'h93, 8'h99: return 2;
      default:             return 4;
    endcase
  endfunction

  function automatic bit op_is_mem(input logic [7:0] op);
    return (op >= 8'h90 && op <= 8'h94) || (op >= 8'h98 && op <= 8'h9A);
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return op >= 8'h98 && op <= 8'h9A;
  endfunction

  function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
    return (addr % op_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] addr);
    int s = op_size(op);
    return 4'(((1 << s) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] din);
    int s = op_size(op);
    if (s == 1) return 32'(din[7:0]) * 32'h01010101;
    if (s == 2) return 32'(din[15:0]) * 32'h00010001;
    return din;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int s = op_size(op);
    logic [31:0] v, mask;
    v    = rdata >> (8 * (addr % 4));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v    = v & mask;
    if ((op == 8'h90 || op == 8'h92) && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one memory op and records what the DUT did; callers judge it.
  task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                        input logic wreg, input logic whilo, input int ack_after,
                        input logic [31:0] rdata, output obs_t o);
    int k;
    o = '0;
    @(negedge clk);
    mem_aluop = op; mem_wd = addr; mem_din = din; mem_wa = 5'($urandom);
    mem_wreg = wreg; mem_whilo = whilo; mem_hilo = {$urandom, $urandom};
    dbus_ack = 1'($urandom); dbus_rdata = $urandom;
    o.sent_wa = mem_wa;
    #1;
    o.stall_cycles = int'(stall_req);
    dbus_ack = 1'b0;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (stall_req !== 1'b1) break;
      k++;
      o.stall_cycles++;
      if (dbus_req !== 1'b1) o.req_dropped = 1'b1;
      if (k == 1) begin
        o.we = dbus_we; o.addr = dbus_addr; o.be = dbus_be; o.wdata = dbus_wdata;
      end else if ({dbus_we, dbus_addr, dbus_be, dbus_wdata} !== {o.we, o.addr, o.be, o.wdata}) begin
        o.unstable = 1'b1;
      end
      dbus_ack   = (k == ack_after);
      dbus_rdata = (k == ack_after) ? rdata : $urandom;
      if (k > 300) begin o.hung = 1'b1; break; end
    end
    o.busy_cycles   = k;
    o.done_req      = dbus_req;
    o.done_zero     = ({dbus_we, dbus_addr, dbus_be, dbus_wdata} === '0);
    o.done_bus_err  = bus_err;
    o.done_addr_err = addr_err;
    o.done_wreg     = wb_wreg;
    o.done_whilo    = wb_whilo;
    // A stray ack outside BUSY must be ignored.
    dbus_ack = 1'b1; dbus_rdata = $urandom;
    mem_aluop = ALUOP_BUBBLE; mem_wreg = 1'b0; mem_whilo = 1'b0;
    @(negedge clk);
    o.post_bus_err  = bus_err;
    o.post_addr_err = addr_err;
    o.post_stall    = stall_req;
    o.wb_wa = wb_wa; o.wb_wreg = wb_wreg; o.wb_wd = wb_wd;
    dbus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_aluop = ALUOP_LW; mem_wd = 32'h100; mem_din = 32'h5555_AAAA; mem_wa = 5'd7;
    mem_wreg = 1'b1; mem_mreg = 1'b1; mem_whilo = 1'b1; mem_hilo = 64'h1234;
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    n_cmp++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo, addr_err, bus_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo, addr_err, bus_err});
    end
    mem_aluop = ALUOP_BUBBLE; mem_wreg = 1'b0; mem_whilo = 1'b0; mem_mreg = 1'b0; dbus_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({stall_req, dbus_req} !== 2'b00) begin n_bad++; $display("FAIL reset_release: got stall/req %b want 00", {stall_req, dbus_req}); end
  endtask

  task automatic test_nonmem();
    logic [7:0] op;
    logic [4:0] p_wa; logic p_wreg, p_whilo; logic [31:0] p_wd; logic [63:0] p_hilo;
    p_wa = '0; p_wreg = '0; p_whilo = '0; p_wd = '0; p_hilo = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if ({wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo} !== {p_wa, p_wreg, p_wd, p_whilo, p_hilo}) begin
          n_bad++;
          $display("FAIL nonmem_wb[%0d]: got %h want %h", i, {wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo},
                   {p_wa, p_wreg, p_wd, p_whilo, p_hilo});
        end
        n_cmp++;
        if ({stall_req, dbus_req, addr_err, bus_err} !== 4'b0) begin
          n_bad++; $display("FAIL nonmem_ctrl[%0d]: got %b want 0000", i, {stall_req, dbus_req, addr_err, bus_err});
        end
      end
      do op = 8'($urandom); while (op_is_mem(op));
      if (i % 7 == 3) op = ALUOP_BUBBLE;
      mem_aluop = op; mem_wa = 5'($urandom); mem_wreg = 1'($urandom); mem_whilo = 1'($urandom);
      mem_wd = $urandom; mem_din = $urandom; mem_hilo = {$urandom, $urandom};
      dbus_ack = 1'($urandom); dbus_rdata = $urandom;
      p_wa = mem_wa; p_wreg = mem_wreg; p_whilo = mem_whilo; p_wd = mem_wd; p_hilo = mem_hilo;
    end
    @(negedge clk);
    mem_aluop = ALUOP_BUBBLE; mem_wreg = 1'b0; mem_whilo = 1'b0; dbus_ack = 1'b0;
  endtask

  task automatic test_lw_basic();
    obs_t o;
    do_mem(ALUOP_LW, 32'h100, $urandom, 1'b1, 1'b0, 3, 32'hDEAD_BEEF, o);
    n_cmp++; if (o.stall_cycles != 4) begin n_bad++; $display("FAIL lw_stall_cycles: got %0d want 4", o.stall_cycles); end
    n_cmp++; if ({o.addr, o.be, o.we} !== {32'h100, 4'b1111, 1'b0}) begin n_bad++; $display("FAIL lw_bus: got %h/%b/%b want 100/1111/0", o.addr, o.be, o.we); end
    n_cmp++; if ({o.req_dropped, o.unstable, o.hung} !== 3'b000) begin n_bad++; $display("FAIL lw_busy_hold: got drop/unstable/hung %b want 000", {o.req_dropped, o.unstable, o.hung}); end
    n_cmp++; if ({o.done_req, o.done_zero} !== 2'b01) begin n_bad++; $display("FAIL lw_done_bus: got req/zero %b want 01", {o.done_req, o.done_zero}); end
    n_cmp++; if (o.wb_wd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_wb_wd: got %h want deadbeef", o.wb_wd); end
    n_cmp++; if ({o.wb_wreg, o.wb_wa} !== {1'b1, o.sent_wa}) begin n_bad++; $display("FAIL lw_wb_wreg_wa: got %b/%0d want 1/%0d", o.wb_wreg, o.wb_wa, o.sent_wa); end
  endtask

  task automatic test_lb_lbu();
    obs_t o;
    do_mem(ALUOP_LB, 32'h103, $urandom, 1'b1, 1'b0, 1, 32'h80FF_FFFF, o);
    n_cmp++; if (o.be !== 4'b1000) begin n_bad++; $display("FAIL lb_be: got %b want 1000", o.be); end
    n_cmp++; if (o.wb_wd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_wb_wd: got %h want ffffff80", o.wb_wd); end
    n_cmp++; if (o.stall_cycles != 2) begin n_bad++; $display("FAIL lb_stall_cycles: got %0d want 2", o.stall_cycles); end
    do_mem(ALUOP_LBU, 32'h103, $urandom, 1'b1, 1'b0, 2, 32'h80FF_FFFF, o);
    n_cmp++; if (o.wb_wd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_wb_wd: got %h want 00000080", o.wb_wd); end
  endtask

  task automatic test_sh();
    obs_t o;
    do_mem(ALUOP_SH, 32'h202, 32'h1234_ABCD, 1'b0, 1'b0, 2, $urandom, o);
    n_cmp++; if ({o.we, o.be} !== {1'b1, 4'b1100}) begin n_bad++; $display("FAIL sh_we_be: got %b/%b want 1/1100", o.we, o.be); end
    n_cmp++; if (o.wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", o.wdata); end
    n_cmp++; if (o.addr !== 32'h200) begin n_bad++; $display("FAIL sh_addr: got %h want 00000200", o.addr); end
    n_cmp++; if (o.wb_wreg !== 1'b0) begin n_bad++; $display("FAIL sh_wb_wreg: got %b want 0", o.wb_wreg); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    logic [7:0]  ops   [4] = '{ALUOP_LW, ALUOP_LH, ALUOP_SH, ALUOP_SW};
    logic [31:0] addrs [4] = '{32'h101, 32'h203, 32'h201, 32'h102};
    for (int i = 0; i < 4; i++) begin
      do_mem(ops[i], addrs[i], $urandom, 1'b1, 1'b1, 1, $urandom, o);
      n_cmp++; if (o.stall_cycles != 0 || o.busy_cycles != 0) begin n_bad++; $display("FAIL misal_stall[%0d]: got stall %0d busy %0d want 0 0", i, o.stall_cycles, o.busy_cycles); end
      n_cmp++; if (o.done_req !== 1'b0) begin n_bad++; $display("FAIL misal_req[%0d]: got %b want 0", i, o.done_req); end
      n_cmp++; if ({o.done_addr_err, o.post_addr_err} !== 2'b10) begin n_bad++; $display("FAIL misal_addr_err[%0d]: got %b want 10", i, {o.done_addr_err, o.post_addr_err}); end
      n_cmp++; if ({o.done_wreg, o.done_whilo} !== 2'b00) begin n_bad++; $display("FAIL misal_wb[%0d]: got wreg/whilo %b want 00", i, {o.done_wreg, o.done_whilo}); end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [31:0] rd;
    do_mem(ALUOP_LW, 32'h300, $urandom, 1'b1, 1'b0, -1, $urandom, o);
    n_cmp++; if (o.busy_cycles != 255 || o.req_dropped) begin n_bad++; $display("FAIL to_busy_cycles: got %0d dropped %b want 255 0", o.busy_cycles, o.req_dropped); end
    n_cmp++; if (o.stall_cycles != 256) begin n_bad++; $display("FAIL to_stall_cycles: got %0d want 256", o.stall_cycles); end
    n_cmp++; if ({o.done_req, o.done_bus_err, o.post_bus_err} !== 3'b010) begin n_bad++; $display("FAIL to_bus_err: got req/err/err+1 %b want 010", {o.done_req, o.done_bus_err, o.post_bus_err}); end
    n_cmp++; if ({o.wb_wreg, o.post_stall} !== 2'b00) begin n_bad++; $display("FAIL to_wb_wreg: got wreg/stall %b want 00", {o.wb_wreg, o.post_stall}); end
    rd = $urandom;
    do_mem(ALUOP_LW, 32'h304, $urandom, 1'b1, 1'b0, 2, rd, o);
    n_cmp++; if (o.stall_cycles != 3 || o.wb_wd !== rd) begin n_bad++; $display("FAIL to_followup: got stall %0d wd %h want 3 %h", o.stall_cycles, o.wb_wd, rd); end
  endtask

  task automatic test_reset_mid_busy();
    obs_t o;
    logic [31:0] rd;
    @(negedge clk);
    mem_aluop = ALUOP_LW; mem_wd = 32'h400; mem_wa = 5'd9; mem_wreg = 1'b1; mem_whilo = 1'b0;
    dbus_ack = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if ({dbus_req, stall_req} !== 2'b11) begin n_bad++; $display("FAIL rst_busy_pre: got req/stall %b want 11", {dbus_req, stall_req}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({dbus_req, stall_req} !== 2'b00) begin n_bad++; $display("FAIL rst_busy_async: got req/stall %b want 00", {dbus_req, stall_req}); end
    n_cmp++;
    if ({dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo, addr_err, bus_err} !== '0) begin
      n_bad++;
      $display("FAIL rst_busy_outputs: got %h want 0",
               {dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo, addr_err, bus_err});
    end
    mem_aluop = ALUOP_BUBBLE; mem_wreg = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd = $urandom;
    do_mem(ALUOP_LHU, 32'h406, $urandom, 1'b1, 1'b0, 2, rd, o);
    n_cmp++; if (o.stall_cycles != 3 || o.be !== 4'b1100) begin n_bad++; $display("FAIL rst_busy_next: got stall %0d be %b want 3 1100", o.stall_cycles, o.be); end
    n_cmp++; if (o.wb_wd !== m_load(ALUOP_LHU, 32'h406, rd)) begin n_bad++; $display("FAIL rst_busy_next_wd: got %h want %h", o.wb_wd, m_load(ALUOP_LHU, 32'h406, rd)); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [7:0]  ops [8] = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h98, 8'h99, 8'h9A};
    logic [7:0]  op;
    logic [31:0] addr, din, rd;
    logic        wreg;
    int          ack;
    for (int i = 0; i < 24; i++) begin
      op   = ops[$urandom_range(0, 7)];
      addr = $urandom;
      din  = $urandom;
      rd   = $urandom;
      ack  = $urandom_range(1, 5);
      wreg = !op_store(op);
      do_mem(op, addr, din, wreg, 1'b0, ack, rd, o);
      if (m_misaligned(op, addr)) begin
        n_cmp++;
        if ({o.stall_cycles != 0, o.done_req, o.done_addr_err, o.done_wreg} !== 4'b0010) begin
          n_bad++; $display("FAIL rnd_misal[%0d]: op %h addr %h got stall %0d req %b err %b wreg %b", i, op, addr,
                            o.stall_cycles, o.done_req, o.done_addr_err, o.done_wreg);
        end
      end else begin
        n_cmp++;
        if (o.stall_cycles != ack + 1 || o.unstable || o.req_dropped || o.done_req !== 1'b0) begin
          n_bad++; $display("FAIL rnd_timing[%0d]: op %h got stall %0d want %0d", i, op, o.stall_cycles, ack + 1);
        end
        n_cmp++;
        if ({o.addr, o.be, o.we} !== {addr & 32'hFFFF_FFFC, m_be(op, addr), 1'(op_store(op))}) begin
          n_bad++; $display("FAIL rnd_bus[%0d]: op %h got %h/%b/%b want %h/%b/%b", i, op, o.addr, o.be, o.we,
                            addr & 32'hFFFF_FFFC, m_be(op, addr), op_store(op));
        end
        if (op_store(op)) begin
          n_cmp++;
          if (o.wdata !== m_wdata(op, din) || o.wb_wreg !== 1'b0) begin
            n_bad++; $display("FAIL rnd_store[%0d]: op %h got %h wreg %b want %h wreg 0", i, op, o.wdata, o.wb_wreg, m_wdata(op, din));
          end
        end else begin
          n_cmp++;
          if ({o.wb_wd, o.wb_wreg, o.wb_wa} !== {m_load(op, addr, rd), 1'b1, o.sent_wa}) begin
            n_bad++; $display("FAIL rnd_load[%0d]: op %h addr %h got %h want %h", i, op, addr, o.wb_wd, m_load(op, addr, rd));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_lw_basic();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
